wr_burst_sfifo_tx: RTL and testbench

//  - Write-side counterpart of the read burst path. Buffers upstream write words in a sync FWFT FIFO and emits

---
 rtl/wr_burst_sfifo_tx_pkg.sv | 25 ++
 rtl/wr_burst_sfifo_tx_if.sv | 36 +++
 rtl/wr_burst_sfifo_tx_fifo.sv | 67 ++++++
 rtl/wr_burst_sfifo_tx.sv | 186 ++++++++++++++++++
 tb/tb_wr_burst_sfifo_tx.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wr_burst_sfifo_tx_pkg.sv
// -----------------------------------------------------------------------------
// wr_burst_sfifo_tx_pkg
// Shared definitions for the write-burst transmit path: data/address widths,
// the default burst length, FSM state encodings and a length-width helper.
// No ports.
// -----------------------------------------------------------------------------
package wr_burst_sfifo_tx_pkg;

    localparam int DSIZE         = 32;
    localparam int ASIZE         = 24;
    localparam int BURST_LEN_DEF = 16;

    // Burst FSM encodings (kept as plain constants for legacy compatibility)
    localparam logic [1:0] WB_IDLE = 2'd0;
    localparam logic [1:0] WB_REQ  = 2'd1;
    localparam logic [1:0] WB_XFER = 2'd2;

    // Width needed to hold a burst length of 1..bl inclusive
    function automatic int len_width(input int bl);
        return $clog2(bl) + 1;
    endfunction

    localparam int LENW_DEF = len_width(BURST_LEN_DEF);

endpackage

// File: rtl/wr_burst_sfifo_tx_if.sv
// -----------------------------------------------------------------------------
// wr_burst_sfifo_tx_if
// Memory-controller write port: burst request/ack handshake plus per-word
// rdy/en data transfer.
//   mc_wr_req   burst request, held until ack
//   mc_wr_addr  burst start word address
//   mc_wr_len   burst length in words
//   mc_wr_ack   controller accepts the request
//   mc_wr_rdy   controller accepts a data word this cycle
//   mc_wr_en    data word transferred this cycle
//   mc_wr_data  burst data word
// Modports: master (burst source), slave (memory controller).
// -----------------------------------------------------------------------------
interface wr_burst_sfifo_tx_if
    import wr_burst_sfifo_tx_pkg::*;
#(
    parameter int LENW = LENW_DEF
);
    logic             mc_wr_req;
    logic [ASIZE-1:0] mc_wr_addr;
    logic [LENW-1:0]  mc_wr_len;
    logic             mc_wr_ack;
    logic             mc_wr_rdy;
    logic             mc_wr_en;
    logic [DSIZE-1:0] mc_wr_data;

    modport master (
        output mc_wr_req, mc_wr_addr, mc_wr_len, mc_wr_en, mc_wr_data,
        input  mc_wr_ack, mc_wr_rdy
    );

    modport slave (
        input  mc_wr_req, mc_wr_addr, mc_wr_len, mc_wr_en, mc_wr_data,
        output mc_wr_ack, mc_wr_rdy
    );
endinterface

// File: rtl/wr_burst_sfifo_tx_fifo.sv
// -----------------------------------------------------------------------------
// wr_sfifo_fwft
// Synchronous first-word-fall-through FIFO, DEPTH x DW, with occupancy count.
// A push while full and a pop while empty are silently ignored.
//   clk, rst    clock, asynchronous active-high reset
//   push        write strobe, push_data written when not full
//   pop         consume head word when not empty
//   head        current head word (valid when count != 0)
//   count       occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module wr_sfifo_fwft #(
    parameter int DEPTH = 512,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != CW'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/wr_burst_sfifo_tx.sv
// -----------------------------------------------------------------------------
// wr_burst_sfifo_tx
// Buffers upstream write words in a FWFT FIFO and emits fixed-length write
// bursts (BURST_LEN words, or a short burst on flush) to the memory controller,
// auto-advancing the burst word address after each completed burst.
//   clk, rst         clock, asynchronous active-high reset
//   us_wr_en/_data   upstream write strobe and word
//   us_afull         count >= DEPTH-AFULL_MARGIN
//   flush            pulse: drain buffered words as a short burst
//   addr_load/base_addr  load the address pointer for the next latched burst
//   mc               memory-controller write port (master side)
//   idle             IDLE, FIFO empty, no flush pending
//   err_wfifo_full   sticky: write attempted while FIFO full
// Optional macro WR_BURST_STATS_EN adds stat_bursts[15:0] / stat_words[23:0],
// saturating counts of completed bursts and words.
// -----------------------------------------------------------------------------
module wr_burst_sfifo_tx
    import wr_burst_sfifo_tx_pkg::*;
#(
    parameter int BURST_LEN    = BURST_LEN_DEF,
    parameter int DEPTH        = 512,
    parameter int AFULL_MARGIN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             us_wr_en,
    input  logic [DSIZE-1:0] us_wr_data,
    output logic             us_afull,
    input  logic             flush,
    input  logic             addr_load,
    input  logic [ASIZE-1:0] base_addr,
    wr_burst_sfifo_tx_if.master mc,
    output logic             idle,
    output logic             err_wfifo_full
`ifdef WR_BURST_STATS_EN
    ,output logic [15:0]     stat_bursts
    ,output logic [23:0]     stat_words
`endif
);
    localparam int LENW = len_width(BURST_LEN);
    localparam int CW   = $clog2(DEPTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic [LENW-1:0]  len_q, len_d;
    logic [LENW-1:0]  rem_q, rem_d;
    logic [ASIZE-1:0] ptr_q, ptr_d;
    logic             flush_pend_q, flush_pend_d;
    logic             err_q, err_d;

    logic [CW-1:0]    fifo_count;
    logic [DSIZE-1:0] fifo_head;
    logic             fifo_empty, fifo_full;
    logic             start_full, start_burst, len_eq_count, flush_clr;
    logic [LENW-1:0]  burst_len;
    logic             xfer_en, burst_done;

    wr_sfifo_fwft #(
        .DEPTH (DEPTH),
        .DW    (DSIZE)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (us_wr_en),
        .push_data (us_wr_data),
        .pop       (xfer_en),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_comb begin
        fifo_empty   = (fifo_count == '0);
        fifo_full    = (fifo_count == CW'(DEPTH));
        start_full   = (fifo_count >= CW'(BURST_LEN));
        // Full bursts win over a pending flush
        burst_len    = start_full ? LENW'(BURST_LEN) : LENW'(fifo_count);
        len_eq_count = (CW'(burst_len) == fifo_count);
        start_burst  = (state_q == WB_IDLE) && (start_full || (flush_pend_q && !fifo_empty));

        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        rem_d      = rem_q;
        err_d      = err_q;
        xfer_en    = 1'b0;
        burst_done = 1'b0;

        case (state_q)
            WB_IDLE: begin
                if (start_burst) begin
                    len_d   = burst_len;
                    addr_d  = ptr_q;
                    state_d = WB_REQ;
                end
            end
            WB_REQ: begin
                if (mc.mc_wr_ack) begin
                    rem_d   = len_q;
                    state_d = WB_XFER;
                end
            end
            WB_XFER: begin
                xfer_en = mc.mc_wr_rdy;
                if (xfer_en) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LENW'(1)) begin
                        burst_done = 1'b1;
                        state_d    = WB_IDLE;
                    end
                end
            end
            default: state_d = WB_IDLE;
        endcase

        flush_clr    = ((state_q == WB_IDLE) && fifo_empty) || (start_burst && len_eq_count);
        flush_pend_d = flush || (flush_pend_q && !flush_clr);

        // A coincident load overrides the post-burst advance
        if (addr_load)       ptr_d = base_addr;
        else if (burst_done) ptr_d = ptr_q + ASIZE'(len_q);
        else                 ptr_d = ptr_q;

        if (us_wr_en && fifo_full) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WB_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            ptr_q        <= '0;
            flush_pend_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            ptr_q        <= ptr_d;
            flush_pend_q <= flush_pend_d;
            err_q        <= err_d;
        end
    end

    assign mc.mc_wr_req  = (state_q == WB_REQ);
    assign mc.mc_wr_addr = addr_q;
    assign mc.mc_wr_len  = len_q;
    assign mc.mc_wr_en   = xfer_en;
    // Data bus is held at zero outside XFER so it shows no stale FIFO contents
    assign mc.mc_wr_data = (state_q == WB_XFER) ? fifo_head : '0;

    assign us_afull       = (fifo_count >= CW'(DEPTH - AFULL_MARGIN));
    assign idle           = (state_q == WB_IDLE) && fifo_empty && !flush_pend_q;
    assign err_wfifo_full = err_q;

`ifdef WR_BURST_STATS_EN
    logic [15:0] stat_bursts_q, stat_bursts_d;
    logic [23:0] stat_words_q, stat_words_d;
    logic [24:0] words_sum;

    always_comb begin
        stat_bursts_d = stat_bursts_q;
        stat_words_d  = stat_words_q;
        words_sum     = {1'b0, stat_words_q} + 25'(len_q);
        if (burst_done) begin
            if (stat_bursts_q != '1) stat_bursts_d = stat_bursts_q + 1'b1;
            stat_words_d = words_sum[24] ? '1 : words_sum[23:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_bursts_q <= '0;
            stat_words_q  <= '0;
        end else begin
            stat_bursts_q <= stat_bursts_d;
            stat_words_q  <= stat_words_d;
        end
    end

    assign stat_bursts = stat_bursts_q;
    assign stat_words  = stat_words_q;
`endif

endmodule

// File: tb/tb_wr_burst_sfifo_tx.sv
module tb_wr_burst_sfifo_tx;
    import wr_burst_sfifo_tx_pkg::*;

    logic             clk;
    logic             rst;
    logic             us_wr_en;
    logic [DSIZE-1:0] us_wr_data;
    logic             us_afull;
    logic             flush;
    logic             addr_load;
    logic [ASIZE-1:0] base_addr;
    logic             idle;
    logic             err_wfifo_full;
`ifdef WR_BURST_STATS_EN
    logic [15:0]      stat_bursts;
    logic [23:0]      stat_words;
`endif

    wr_burst_sfifo_tx_if mc_if ();

    wr_burst_sfifo_tx dut (
        .clk            (clk),
        .rst            (rst),
        .us_wr_en       (us_wr_en),
        .us_wr_data     (us_wr_data),
        .us_afull       (us_afull),
        .flush          (flush),
        .addr_load      (addr_load),
        .base_addr      (base_addr),
        .mc             (mc_if.master),
        .idle           (idle),
        .err_wfifo_full (err_wfifo_full)
`ifdef WR_BURST_STATS_EN
        ,.stat_bursts   (stat_bursts)
        ,.stat_words    (stat_words)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Memory-controller responder configuration and capture
    logic        ack_en     = 1'b1;
    int          ack_delay  = 1;
    logic        rdy_random = 1'b0;
    int          stable_err = 0;
    logic [31:0] hdr_addr_q [$];
    logic [31:0] hdr_len_q  [$];
    logic [31:0] data_q     [$];

    initial begin : responder
        logic             in_req;
        int               wait_cnt;
        logic [ASIZE-1:0] req_addr;
        logic [4:0]       req_len;
        in_req = 1'b0;
        wait_cnt = 0;
        req_addr = '0;
        req_len = '0;
        mc_if.mc_wr_ack = 1'b0;
        mc_if.mc_wr_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (mc_if.mc_wr_req) begin
                if (!in_req) begin
                    in_req   = 1'b1;
                    wait_cnt = 0;
                    req_addr = mc_if.mc_wr_addr;
                    req_len  = mc_if.mc_wr_len;
                end else begin
                    if (mc_if.mc_wr_addr !== req_addr || mc_if.mc_wr_len !== req_len)
                        stable_err++;
                    wait_cnt++;
                end
                if (ack_en && wait_cnt >= ack_delay) begin
                    mc_if.mc_wr_ack = 1'b1;
                    hdr_addr_q.push_back(32'(req_addr));
                    hdr_len_q.push_back(32'(req_len));
                end else begin
                    mc_if.mc_wr_ack = 1'b0;
                end
            end else begin
                mc_if.mc_wr_ack = 1'b0;
                in_req = 1'b0;
            end
            mc_if.mc_wr_rdy = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (mc_if.mc_wr_en === 1'b1) data_q.push_back(mc_if.mc_wr_data);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input int n, input logic [31:0] start);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            us_wr_en   = 1'b1;
            us_wr_data = start + 32'(i);
        end
        @(negedge clk);
        us_wr_en = 1'b0;
    endtask

    task automatic load_base(input logic [ASIZE-1:0] a);
        @(negedge clk);
        addr_load = 1'b1;
        base_addr = a;
        @(negedge clk);
        addr_load = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_done(input int nh, input int nw, input int budget, input string tag);
        int cyc;
        cyc = 0;
        while ((hdr_addr_q.size() < nh || data_q.size() < nw) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_timeout"}, 64'(cyc < budget), 64'd1);
    endtask

    task automatic check_burst(input int idx, input logic [31:0] addr, input logic [31:0] len, input string tag);
        if (idx < hdr_addr_q.size()) begin
            chk({tag, "_addr"}, 64'(hdr_addr_q[idx]), 64'(addr));
            chk({tag, "_len"},  64'(hdr_len_q[idx]),  64'(len));
        end else begin
            chk({tag, "_missing"}, 64'(hdr_addr_q.size()), 64'(idx + 1));
        end
    endtask

    task automatic check_data(input int n, input logic [31:0] start, input string tag);
        chk({tag, "_count"}, 64'(data_q.size()), 64'(n));
        for (int i = 0; i < n && i < data_q.size(); i++)
            chk({tag, "_word"}, 64'(data_q[i]), 64'(start + 32'(i)));
    endtask

    task automatic clear_capture();
        hdr_addr_q.delete();
        hdr_len_q.delete();
        data_q.delete();
    endtask

    initial begin : stimulus
        rst = 1'b1;
        us_wr_en = 1'b0;
        us_wr_data = '0;
        flush = 1'b0;
        addr_load = 1'b0;
        base_addr = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_req",  64'(mc_if.mc_wr_req),  64'd0);
        chk("rst_addr", 64'(mc_if.mc_wr_addr), 64'd0);
        chk("rst_len",  64'(mc_if.mc_wr_len),  64'd0);
        chk("rst_en",   64'(mc_if.mc_wr_en),   64'd0);
        chk("rst_data", 64'(mc_if.mc_wr_data), 64'd0);
        chk("rst_afull", 64'(us_afull), 64'd0);
        chk("rst_err",  64'(err_wfifo_full), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        rst = 1'b0;

        // 1: full burst from base 0x100, then next burst at 0x110
        load_base(24'h100);
        push_words(16, 32'd0);
        chk("t1_req_latency0", 64'(mc_if.mc_wr_req), 64'd0);
        @(negedge clk);
        chk("t1_req_latency1", 64'(mc_if.mc_wr_req), 64'd1);
        chk("t1_req_addr", 64'(mc_if.mc_wr_addr), 64'h100);
        chk("t1_req_len",  64'(mc_if.mc_wr_len),  64'd16);
        wait_done(1, 16, 200, "t1a");
        check_burst(0, 32'h100, 32'd16, "t1a");
        check_data(16, 32'd0, "t1a");
        push_words(16, 32'd16);
        wait_done(2, 32, 200, "t1b");
        check_burst(1, 32'h110, 32'd16, "t1b");
        check_data(32, 32'd0, "t1b");
        repeat (3) @(negedge clk);
        chk("t1_idle", 64'(idle), 64'd1);

        // 2: 5-word flush burst, then pointer lands on 0x105
        clear_capture();
        load_base(24'h100);
        push_words(5, 32'h500);
        repeat (2) @(negedge clk);
        chk("t2_no_req_before_flush", 64'(mc_if.mc_wr_req), 64'd0);
        pulse_flush();
        wait_done(1, 5, 200, "t2");
        check_burst(0, 32'h100, 32'd5, "t2");
        check_data(5, 32'h500, "t2");
        repeat (3) @(negedge clk);
        chk("t2_idle", 64'(idle), 64'd1);
        clear_capture();
        push_words(1, 32'h600);
        pulse_flush();
        wait_done(1, 1, 200, "t2p");
        check_burst(0, 32'h105, 32'd1, "t2_ptr");
        check_data(1, 32'h600, "t2p");

        // 3: 64 words, ack after 7 cycles, random rdy
        repeat (3) @(negedge clk);
        clear_capture();
        ack_delay  = 7;
        rdy_random = 1'b1;
        stable_err = 0;
        load_base(24'h200);
        push_words(64, 32'h3000);
        wait_done(4, 64, 2000, "t3");
        repeat (20) @(negedge clk);
        chk("t3_bursts", 64'(hdr_addr_q.size()), 64'd4);
        for (int b = 0; b < 4; b++)
            check_burst(b, 32'h200 + 32'(16 * b), 32'd16, "t3");
        check_data(64, 32'h3000, "t3");
        chk("t3_stable", 64'(stable_err), 64'd0);
        chk("t3_idle", 64'(idle), 64'd1);

        // 4: no ack, overfill
        ack_delay  = 1;
        rdy_random = 1'b0;
        ack_en     = 1'b0;
        push_words(503, 32'h0);
        chk("t4_afull_503", 64'(us_afull), 64'd0);
        push_words(1, 32'h0);
        chk("t4_afull_504", 64'(us_afull), 64'd1);
        push_words(8, 32'h0);
        chk("t4_count_512", 64'(dut.fifo_count), 64'd512);
        chk("t4_err_before", 64'(err_wfifo_full), 64'd0);
        push_words(1, 32'h0);
        chk("t4_count_drop", 64'(dut.fifo_count), 64'd512);
        chk("t4_err_set", 64'(err_wfifo_full), 64'd1);
        repeat (5) @(negedge clk);
        chk("t4_err_sticky", 64'(err_wfifo_full), 64'd1);
        chk("t4_stable", 64'(stable_err), 64'd0);

        // 5: reset during XFER after 3 words
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        clear_capture();
        load_base(24'h300);
        push_words(16, 32'h7000);
        begin
            int cyc;
            cyc = 0;
            while (data_q.size() < 3 && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            chk("t5_timeout", 64'(cyc < 200), 64'd1);
        end
        #2 rst = 1'b1;
        #1;
        chk("t5_req",  64'(mc_if.mc_wr_req),  64'd0);
        chk("t5_addr", 64'(mc_if.mc_wr_addr), 64'd0);
        chk("t5_len",  64'(mc_if.mc_wr_len),  64'd0);
        chk("t5_en",   64'(mc_if.mc_wr_en),   64'd0);
        chk("t5_data", 64'(mc_if.mc_wr_data), 64'd0);
        chk("t5_afull", 64'(us_afull), 64'd0);
        chk("t5_err",  64'(err_wfifo_full), 64'd0);
        chk("t5_idle", 64'(idle), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_idle_after", 64'(idle), 64'd1);
        chk("t5_count_after", 64'(dut.fifo_count), 64'd0);

`ifdef WR_BURST_STATS_EN
        // 6: 3 full bursts plus one 4-word flush burst
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_capture();
        load_base(24'h0);
        push_words(48, 32'h8000);
        wait_done(3, 48, 500, "t6a");
        push_words(4, 32'h9000);
        pulse_flush();
        wait_done(4, 52, 500, "t6b");
        repeat (3) @(negedge clk);
        chk("t6_bursts", 64'(stat_bursts), 64'd4);
        chk("t6_words",  64'(stat_words),  64'd52);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
